asine: RTL and testbench

Inverse of the team's one-shot sine lookup. Takes an 8-bit offset-binary amplitude and returns the 8-bit phase on the rising segment of the 256-entry sine table whose entry is the smallest value not less than that amplitude. It runs a fixed-length iterative binary search over the shared table behind valid/ready handshakes on both sides. It sits downstream of amplitude sources (ADC capture, demodulators) wherever a phase estimate is needed.

---
 rtl/asine_pkg.sv | 58 +++++
 rtl/asine_if.sv | 27 ++
 rtl/asine.sv | 130 +++++++++++++
 tb/tb_asine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/asine_pkg.sv
// Shared sine definitions: the 256-entry offset-binary sine table, rising-segment
// constants and the inverse-lookup FSM state encoding.
package asine_pkg;

    localparam int DATA_W = 32'd8;

    localparam logic [7:0] SEG_BASE     = 8'd192;
    localparam logic [8:0] SEG_LEN      = 9'd129;
    localparam logic [3:0] SEARCH_ITERS = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } asine_state_e;

    // round(128 + 127*sin(2*pi*i/256)), shared with the forward sine lookup
    localparam logic [7:0] SINETABLE_256 [0:255] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
        8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
        8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
        8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
        8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd254, 8'd253,
        8'd253, 8'd252, 8'd251, 8'd250, 8'd250, 8'd249, 8'd248, 8'd246,
        8'd245, 8'd244, 8'd243, 8'd241, 8'd240, 8'd239, 8'd237, 8'd235,
        8'd234, 8'd232, 8'd230, 8'd228, 8'd226, 8'd224, 8'd222, 8'd220,
        8'd218, 8'd216, 8'd213, 8'd211, 8'd209, 8'd206, 8'd204, 8'd201,
        8'd199, 8'd196, 8'd193, 8'd191, 8'd188, 8'd185, 8'd182, 8'd179,
        8'd177, 8'd174, 8'd171, 8'd168, 8'd165, 8'd162, 8'd159, 8'd156,
        8'd153, 8'd150, 8'd147, 8'd144, 8'd140, 8'd137, 8'd134, 8'd131,
        8'd128, 8'd125, 8'd122, 8'd119, 8'd116, 8'd112, 8'd109, 8'd106,
        8'd103, 8'd100, 8'd97,  8'd94,  8'd91,  8'd88,  8'd85,  8'd82,
        8'd79,  8'd77,  8'd74,  8'd71,  8'd68,  8'd65,  8'd63,  8'd60,
        8'd57,  8'd55,  8'd52,  8'd50,  8'd47,  8'd45,  8'd43,  8'd40,
        8'd38,  8'd36,  8'd34,  8'd32,  8'd30,  8'd28,  8'd26,  8'd24,
        8'd22,  8'd21,  8'd19,  8'd17,  8'd16,  8'd15,  8'd13,  8'd12,
        8'd11,  8'd10,  8'd8,   8'd7,   8'd6,   8'd6,   8'd5,   8'd4,
        8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd1,   8'd1,   8'd1,
        8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,
        8'd3,   8'd4,   8'd5,   8'd6,   8'd6,   8'd7,   8'd8,   8'd10,
        8'd11,  8'd12,  8'd13,  8'd15,  8'd16,  8'd17,  8'd19,  8'd21,
        8'd22,  8'd24,  8'd26,  8'd28,  8'd30,  8'd32,  8'd34,  8'd36,
        8'd38,  8'd40,  8'd43,  8'd45,  8'd47,  8'd50,  8'd52,  8'd55,
        8'd57,  8'd60,  8'd63,  8'd65,  8'd68,  8'd71,  8'd74,  8'd77,
        8'd79,  8'd82,  8'd85,  8'd88,  8'd91,  8'd94,  8'd97,  8'd100,
        8'd103, 8'd106, 8'd109, 8'd112, 8'd116, 8'd119, 8'd122, 8'd125
    };

    // Segment index k (0..128) to table phase; the 8-bit add wraps modulo 256.
    function automatic logic [7:0] seg_phase(input logic [7:0] k);
        return k + SEG_BASE;
    endfunction

endpackage

// File: rtl/asine_if.sv
// Request/response handshake bundle between an amplitude source, the inverse
// sine block and the phase consumer.
interface asine_if
    import asine_pkg::*;
#(
    parameter int DW = DATA_W
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] amp;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] phase;
    logic          clipped;

    modport master (
        output in_valid, amp, out_ready,
        input  in_ready, out_valid, phase, clipped
    );

    modport slave (
        input  in_valid, amp, out_ready,
        output in_ready, out_valid, phase, clipped
    );

endinterface

// File: rtl/asine.sv
// Inverse sine: fixed 8-step binary search over the rising half of the shared
// sine table, returning the smallest phase whose entry is >= the amplitude.
module asine
    import asine_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic   clk,
    input  logic   nreset,
    asine_if.slave bus
);

    if (DW != 8) begin : g_unsupported
        $error("asine: unsupported DW=%0d, only DW=8 is implemented", DW);
    end

    asine_state_e  state_r;
    asine_state_e  state_nx_s;
    logic [DW-1:0] amp_r;
    logic [DW-1:0] phase_r;
    logic          clipped_r;
    logic [7:0]    lo_r;
    logic [7:0]    hi_r;
    logic [3:0]    it_r;
    logic [7:0]    mid_s;
    logic [7:0]    probe_s;
    logic [7:0]    lo_step_s;
    logic [7:0]    hi_step_s;
    logic          last_step_s;

    // One search step: probe the window midpoint and halve the window towards the answer.
    always_comb begin
        mid_s       = 8'(({1'b0, lo_r} + {1'b0, hi_r}) >> 1);
        probe_s     = SINETABLE_256[seg_phase(mid_s)];
        lo_step_s   = lo_r;
        hi_step_s   = hi_r;
        last_step_s = (it_r == (SEARCH_ITERS - 4'd1));
        if (lo_r == hi_r) begin
            lo_step_s = lo_r;
            hi_step_s = hi_r;
        end else if (probe_s >= amp_r) begin
            hi_step_s = mid_s;
        end else begin
            lo_step_s = mid_s + 8'd1;
        end
    end

    // Next-state decode: accept in IDLE, fixed step count in SEARCH, hold in DONE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = SEARCH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEARCH: begin
                if (last_step_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SEARCH;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Search window, captured amplitude and the result registers.
    always_ff @(posedge clk) begin
        if (nreset) begin
            amp_r     <= {DW{1'b0}};
            lo_r      <= 8'd0;
            hi_r      <= 8'd0;
            it_r      <= 4'd0;
            phase_r   <= {DW{1'b0}};
            clipped_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        amp_r <= bus.amp;
                        lo_r  <= 8'd0;
                        hi_r  <= 8'(SEG_LEN - 9'd1);
                        it_r  <= 4'd0;
                    end
                end
                SEARCH: begin
                    lo_r <= lo_step_s;
                    hi_r <= hi_step_s;
                    it_r <= it_r + 4'd1;
                    // The window has collapsed by the last step, so lo is the answer.
                    if (last_step_s) begin
                        phase_r   <= seg_phase(lo_step_s);
                        clipped_r <= (amp_r == {DW{1'b0}});
                    end
                end
                DONE: begin
                    amp_r <= amp_r;
                end
                default: begin
                    amp_r <= amp_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.phase     = phase_r;
    assign bus.clipped   = clipped_r;

endmodule

// File: tb/tb_asine.sv
// Self-checking bench for asine: directed endpoints, backpressure, reset
// mid-search and a randomized-backpressure sweep against a $sin-based model.
module tb_asine;

    logic clk = 1'b0;
    logic nreset;

    asine_if #(.DW(8)) bus ();

    asine #(.DW(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] ref_tab [256];

    // Smallest k on the rising segment whose table entry reaches the amplitude.
    function automatic logic [7:0] model_phase(input logic [7:0] a);
        for (int k = 0; k <= 128; k++) begin
            if (ref_tab[(k + 192) % 256] >= a) return 8'((k + 192) % 256);
        end
        return 8'd0;
    endfunction

    function automatic logic model_clip(input logic [7:0] a);
        return (a == 8'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and retire it; reports latency, result and whether all waits completed.
    task automatic run_txn(input logic [7:0] a, input int hold, output int lat,
                           output logic [7:0] ph, output logic cl, output logic ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) ok = 1'b0;
        bus.amp      = a;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
        if (lat >= 50) ok = 1'b0;
        ph = bus.phase;
        cl = bus.clipped;
        for (int i = 0; i < hold; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic [7:0] ph; logic cl; logic ok;
        bus.in_valid = 1'b0; bus.amp = 8'd0; bus.out_ready = 1'b0;
        nreset = 1'b1;
        tick(); tick();
        nreset = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.phase !== 8'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
        checks++; if (bus.clipped !== 1'b0) begin failures++; $display("FAIL reset_clipped got=%b exp=0", bus.clipped); end
        run_txn(8'd128, 0, lat, ph, cl, ok);
        checks++; if (!ok) begin failures++; $display("FAIL first_txn_timeout got=timeout exp=done"); end
        checks++; if (lat != 8) begin failures++; $display("FAIL first_latency got=%0d exp=8", lat); end
        checks++; if (ph !== 8'd0) begin failures++; $display("FAIL first_phase got=%0d exp=0", ph); end
        checks++; if (cl !== 1'b0) begin failures++; $display("FAIL first_clipped got=%b exp=0", cl); end
    endtask

    task automatic test_endpoints();
        logic [7:0] amps [5];
        logic [7:0] exps [5];
        logic       clps [5];
        int lat; logic [7:0] ph; logic cl; logic ok;
        amps = '{8'd255, 8'd1,   8'd2,   8'd129, 8'd0};
        exps = '{8'd61,  8'd192, 8'd196, 8'd1,   8'd192};
        clps = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
        for (int i = 0; i < 5; i++) begin
            run_txn(amps[i], i, lat, ph, cl, ok);
            checks++; if (!ok || lat != 8) begin failures++; $display("FAIL endpoint_latency amp=%0d got=%0d exp=8", amps[i], lat); end
            checks++; if (ph !== exps[i]) begin failures++; $display("FAIL endpoint_phase amp=%0d got=%0d exp=%0d", amps[i], ph, exps[i]); end
            checks++; if (cl !== clps[i]) begin failures++; $display("FAIL endpoint_clipped amp=%0d got=%b exp=%b", amps[i], cl, clps[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a, ph0; logic cl0; int n; int bad;
        a = 8'($urandom_range(0, 255));
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        bus.amp = a; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n != 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", n); end
        ph0 = bus.phase; cl0 = bus.clipped;
        checks++; if (ph0 !== model_phase(a)) begin failures++; $display("FAIL bp_phase amp=%0d got=%0d exp=%0d", a, ph0, model_phase(a)); end
        checks++; if (cl0 !== model_clip(a)) begin failures++; $display("FAIL bp_clipped amp=%0d got=%b exp=%b", a, cl0, model_clip(a)); end
        // A competing request waits the whole time and through the handshake edge.
        bus.in_valid = 1'b1; bus.amp = 8'($urandom_range(0, 255));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.phase !== ph0 || bus.clipped !== cl0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable got=%0d_bad_cycles exp=0", bad); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_handshake_ignores_req got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_single_handshake got=v%b_r%b exp=v0_r1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_reset_mid_search();
        int lat; logic [7:0] ph; logic cl; logic ok; int pulses; int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        bus.amp = 8'd200; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        nreset = 1'b1;
        tick();
        nreset = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_handshake got=r%b_v%b exp=r1_v0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.phase !== 8'd0 || bus.clipped !== 1'b0) begin failures++; $display("FAIL midrst_result got=%0d/%b exp=0/0", bus.phase, bus.clipped); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
        run_txn(8'd200, 1, lat, ph, cl, ok);
        checks++; if (!ok || lat != 8) begin failures++; $display("FAIL midrst_retry_latency got=%0d exp=8", lat); end
        checks++; if (ph !== model_phase(8'd200) || cl !== 1'b0) begin failures++; $display("FAIL midrst_retry_phase got=%0d/%b exp=%0d/0", ph, cl, model_phase(8'd200)); end
    endtask

    task automatic test_sweep();
        int lat; logic [7:0] ph; logic cl; logic ok; logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            run_txn(a, int'($urandom_range(0, 3)), lat, ph, cl, ok);
            checks++; if (!ok || lat != 8) begin failures++; $display("FAIL sweep_latency amp=%0d got=%0d exp=8", a, lat); end
            checks++; if (ph !== model_phase(a)) begin failures++; $display("FAIL sweep_phase amp=%0d got=%0d exp=%0d", a, ph, model_phase(a)); end
            checks++; if (cl !== model_clip(a)) begin failures++; $display("FAIL sweep_clipped amp=%0d got=%b exp=%b", a, cl, model_clip(a)); end
        end
    endtask

    initial begin
        real pi;
        pi = 3.141592653589793;
        for (int i = 0; i < 256; i++) begin
            ref_tab[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * pi * real'(i) / 256.0) + 0.5));
        end
        test_reset();
        test_endpoints();
        test_backpressure();
        test_reset_mid_search();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "tb_asine watchdog expired");
    end

endmodule
